// File: rtl/pad_mux_pkg.sv
// Shared types and default parameters for the pad pin-mux controller.
package pad_mux_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    DRAIN  = 1'b1
  } lane_state_e;

  localparam int DEF_NPAD        = 8;
  localparam int DEF_NFUNC       = 4;
  localparam int DEF_DEAD_CYC    = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Width of a per-pad function select field.
  function automatic int fw_of(input int nfunc);
    return (nfunc > 1) ? $clog2(nfunc) : 1;
  endfunction

endpackage

// File: rtl/pad_mux_lane.sv
// One pad lane: owner-select FSM with break-before-make drain, output
// registers and input synchroniser.
module pad_mux_lane
  import pad_mux_pkg::*;
#(
  parameter int NFUNC       = DEF_NFUNC,
  parameter int DEAD_CYC    = DEF_DEAD_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int FW         = fw_of(NFUNC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [FW-1:0]    cfg_sel_i,
  input  logic [NFUNC-1:0] fn_c2p_i,
  input  logic [NFUNC-1:0] fn_c2p_en_i,
  output logic [NFUNC-1:0] fn_p2c_o,
  output logic             pad_c2p_o,
  output logic             pad_c2p_en_o,
  input  logic             pad_p2c_i,
  output logic             busy_o
);

  localparam int            CW         = $clog2(DEAD_CYC + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DEAD_CYC - 1);

  lane_state_e            state_q;
  logic [FW-1:0]          cur_sel_q;
  logic [FW-1:0]          tgt_sel_q;
  logic [CW-1:0]          cnt_q;
  logic                   c2p_q;
  logic                   c2p_en_q;
  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: non-blocking assignments so every lane register updates from the
  // values present before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ACTIVE;
      cur_sel_q <= '0;
      tgt_sel_q <= '0;
      cnt_q     <= '0;
      c2p_q     <= 1'b0;
      c2p_en_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ACTIVE: begin
          if (cfg_sel_i != cur_sel_q) begin
            tgt_sel_q <= cfg_sel_i;
            cnt_q     <= CNT_RELOAD;
            state_q   <= DRAIN;
            c2p_q     <= 1'b0;
            c2p_en_q  <= 1'b0;
          end else begin
            c2p_q    <= fn_c2p_i[cur_sel_q];
            c2p_en_q <= fn_c2p_en_i[cur_sel_q];
          end
        end
        DRAIN: begin
          c2p_q    <= 1'b0;
          c2p_en_q <= 1'b0;
          // A new request, even back to the current owner, restarts the drain.
          if (cfg_sel_i != tgt_sel_q) begin
            tgt_sel_q <= cfg_sel_i;
            cnt_q     <= CNT_RELOAD;
          end else if (cnt_q == '0) begin
            cur_sel_q <= tgt_sel_q;
            state_q   <= ACTIVE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ACTIVE;
      endcase
    end
  end

  // NOTE: synchroniser flops are reset so fn_p2c_o is a known 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_p2c_i};
    end
  end

  always_comb begin
    fn_p2c_o            = '0;
    fn_p2c_o[cur_sel_q] = sync_q[SYNC_STAGES-1];
  end

  assign pad_c2p_o    = c2p_q;
  assign pad_c2p_en_o = c2p_en_q;
  assign busy_o       = (state_q == DRAIN);

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pin-mux controller: NPAD independent lanes sharing pads between NFUNC
// functions; slices the function-major flattened buses per pad.
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int NPAD        = DEF_NPAD,
  parameter int NFUNC       = DEF_NFUNC,
  parameter int DEAD_CYC    = DEF_DEAD_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int FW         = fw_of(NFUNC)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NPAD*FW-1:0]    cfg_sel_i,
  input  logic [NFUNC*NPAD-1:0] fn_c2p_i,
  input  logic [NFUNC*NPAD-1:0] fn_c2p_en_i,
  output logic [NFUNC*NPAD-1:0] fn_p2c_o,
  output logic [NPAD-1:0]       pad_c2p_o,
  output logic [NPAD-1:0]       pad_c2p_en_o,
  input  logic [NPAD-1:0]       pad_p2c_i,
  output logic [NPAD-1:0]       busy_o
);

  for (genvar p = 0; p < NPAD; p++) begin : g_lane
    logic [NFUNC-1:0] lane_c2p;
    logic [NFUNC-1:0] lane_c2p_en;
    logic [NFUNC-1:0] lane_p2c;

    // Function-major bus: bit f*NPAD+p belongs to function f on pad p.
    for (genvar f = 0; f < NFUNC; f++) begin : g_fn
      assign lane_c2p[f]            = fn_c2p_i[f*NPAD+p];
      assign lane_c2p_en[f]         = fn_c2p_en_i[f*NPAD+p];
      assign fn_p2c_o[f*NPAD+p]     = lane_p2c[f];
    end

    pad_mux_lane #(
      .NFUNC       (NFUNC),
      .DEAD_CYC    (DEAD_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_sel_i    (cfg_sel_i[p*FW +: FW]),
      .fn_c2p_i     (lane_c2p),
      .fn_c2p_en_i  (lane_c2p_en),
      .fn_p2c_o     (lane_p2c),
      .pad_c2p_o    (pad_c2p_o[p]),
      .pad_c2p_en_o (pad_c2p_en_o[p]),
      .pad_p2c_i    (pad_p2c_i[p]),
      .busy_o       (busy_o[p])
    );
  end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Self-checking bench for pad_mux_ctrl: table-driven passthrough vectors plus
// directed sequences for drain, restart, input sync and async reset.
module tb_pad_mux_ctrl;

  localparam int NPAD  = 8;
  localparam int NFUNC = 4;
  localparam int FW    = 2;
  localparam int DEAD  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NPAD*FW-1:0]    cfg_sel = '0;
  logic [NFUNC*NPAD-1:0] fn_c2p = '0;
  logic [NFUNC*NPAD-1:0] fn_c2p_en = '0;
  logic [NFUNC*NPAD-1:0] fn_p2c;
  logic [NPAD-1:0]       pad_c2p;
  logic [NPAD-1:0]       pad_c2p_en;
  logic [NPAD-1:0]       pad_p2c = '0;
  logic [NPAD-1:0]       busy;

  int n_checks = 0;
  int n_fail   = 0;

  pad_mux_ctrl #(
    .NPAD        (NPAD),
    .NFUNC       (NFUNC),
    .DEAD_CYC    (DEAD),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_sel_i    (cfg_sel),
    .fn_c2p_i     (fn_c2p),
    .fn_c2p_en_i  (fn_c2p_en),
    .fn_p2c_o     (fn_p2c),
    .pad_c2p_o    (pad_c2p),
    .pad_c2p_en_o (pad_c2p_en),
    .pad_p2c_i    (pad_p2c),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c2p;
    logic [31:0] en;
    logic [7:0]  exp_c2p;
    logic [7:0]  exp_en;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hA5A5_5A3C, 32'hFFFF_00F0, 8'h3C, 8'hF0};
    vecs[1] = '{32'h0000_00FF, 32'h0000_0000, 8'hFF, 8'h00};
    vecs[2] = '{32'hFFFF_FF00, 32'hFFFF_FF81, 8'h00, 8'h81};
    vecs[3] = '{32'h1234_5666, 32'h0F0F_0F5A, 8'h66, 8'h5A};

    // Reset state
    step();
    step();
    check("rst_c2p", 64'(pad_c2p), 64'h0);
    check("rst_en", 64'(pad_c2p_en), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_p2c", 64'(fn_p2c), 64'h0);

    // First ACTIVE cycle loads function 0
    fn_c2p    = 32'h0000_0001;
    fn_c2p_en = 32'h0000_0001;
    rst       = 1'b0;
    step();
    check("first_en0", 64'(pad_c2p_en[0]), 64'h1);
    check("first_c2p0", 64'(pad_c2p[0]), 64'h1);
    check("first_busy", 64'(busy), 64'h0);

    // Passthrough table with every pad owned by function 0
    for (int i = 0; i < 4; i++) begin
      fn_c2p    = vecs[i].c2p;
      fn_c2p_en = vecs[i].en;
      step();
      check($sformatf("tbl%0d_c2p", i), 64'(pad_c2p), 64'(vecs[i].exp_c2p));
      check($sformatf("tbl%0d_en", i), 64'(pad_c2p_en), 64'(vecs[i].exp_en));
      check($sformatf("tbl%0d_busy", i), 64'(busy), 64'h0);
    end

    // Pad 2: function 0 -> 3
    fn_c2p    = 32'h0400_00AA;
    fn_c2p_en = 32'h0400_00FF;
    step();
    check("p2_base_en", 64'(pad_c2p_en), 64'hFF);
    cfg_sel = 16'h0030;
    for (int i = 0; i <= DEAD + 1; i++) begin
      step();
      check($sformatf("p2_en_%0d", i), 64'(pad_c2p_en[2]), 64'(i == DEAD + 1));
      check($sformatf("p2_busy_%0d", i), 64'(busy), (i < DEAD) ? 64'h04 : 64'h00);
      check($sformatf("p2_others_%0d", i), 64'(pad_c2p_en & 8'hFB), 64'hFB);
    end
    check("p2_c2p_fn3", 64'(pad_c2p[2]), 64'h1);
    check("p2_c2p_all", 64'(pad_c2p), 64'hAE);

    // Pad 1: 0 -> 2, then back to 0 two cycles later restarts the drain
    fn_c2p_en = 32'h0402_00FF;
    cfg_sel   = 16'h0038;
    step();
    check("p1_en_t0", 64'(pad_c2p_en[1]), 64'h0);
    step();
    check("p1_en_t1", 64'(pad_c2p_en[1]), 64'h0);
    cfg_sel = 16'h0030;
    for (int i = 0; i <= DEAD; i++) begin
      step();
      check($sformatf("p1_rst_en_%0d", i), 64'(pad_c2p_en[1]), 64'h0);
      check($sformatf("p1_rst_busy_%0d", i), 64'(busy[1]), 64'(i < DEAD));
    end
    step();
    check("p1_back_en", 64'(pad_c2p_en[1]), 64'h1);
    check("p1_back_c2p_fn0", 64'(pad_c2p[1]), 64'h1);
    check("p1_back_busy", 64'(busy), 64'h0);

    // Pad 5 -> function 1, then route pad inputs
    cfg_sel = 16'h0430;
    for (int i = 0; i <= DEAD; i++) step();
    check("p5_settled_busy", 64'(busy), 64'h0);
    pad_p2c = 8'h21;
    step();
    check("p5_sync1", 64'(fn_p2c), 64'h0);
    step();
    check("p5_sync2", 64'(fn_p2c), 64'h0000_2001);
    pad_p2c = 8'h01;
    step();
    check("p5_fall1", 64'(fn_p2c), 64'h0000_2001);
    step();
    check("p5_fall2", 64'(fn_p2c), 64'h0000_0001);

    // Async reset in the middle of a pad 4 drain
    pad_p2c = 8'h21;
    step();
    step();
    cfg_sel = 16'h0630;
    step();
    step();
    check("p4_draining", 64'(busy[4]), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_c2p", 64'(pad_c2p), 64'h0);
    check("mid_rst_en", 64'(pad_c2p_en), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_p2c", 64'(fn_p2c), 64'h0);
    cfg_sel = '0;
    pad_p2c = 8'h10;
    step();
    rst = 1'b0;
    step();
    check("post_rst_en", 64'(pad_c2p_en), 64'hFF);
    check("post_rst_c2p", 64'(pad_c2p), 64'hAA);
    check("post_rst_busy", 64'(busy), 64'h0);
    step();
    check("post_rst_p2c_fn0", 64'(fn_p2c), 64'h0000_0010);

    // All pads switch to function 2 on the same edge
    fn_c2p    = 32'h005A_00AA;
    fn_c2p_en = 32'h00FF_00FF;
    step();
    cfg_sel = 16'hAAAA;
    for (int i = 0; i <= DEAD + 1; i++) begin
      step();
      check($sformatf("all_en_%0d", i), 64'(pad_c2p_en), (i == DEAD + 1) ? 64'hFF : 64'h00);
      check($sformatf("all_busy_%0d", i), 64'(busy), (i < DEAD) ? 64'hFF : 64'h00);
    end
    check("all_c2p_fn2", 64'(pad_c2p), 64'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
